pow_seq: RTL and testbench

//  Sequencer for a general integer-power datapath: computes base**exp mod 2**RES_W
//  by LSB-first square-and-multiply, time-sharing ONE multiplier between the

---
 rtl/pow_seq_pkg.sv | 15 +
 rtl/pow_seq_mul_unit.sv | 18 +
 rtl/pow_seq.sv | 124 ++++++++++++
 tb/tb_pow_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pow_seq_pkg.sv
// Shared definitions for the pow_seq integer-power sequencer.
// State encoding and default widths.
package pow_seq_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_EXP_W  = 4;
   localparam int unsigned DEF_RES_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pow_seq_mul_unit.sv
// Shared RES_W x RES_W multiplier: low half of the product plus a flag that
// the high half is nonzero (product did not fit in RES_W bits).
module pow_seq_mul_unit #(
   parameter int unsigned RES_W = 32
) (
   input  logic [RES_W-1:0] op_a,
   input  logic [RES_W-1:0] op_b,
   output logic [RES_W-1:0] prod_lo,
   output logic             hi_nz
);

   logic [2*RES_W-1:0] prod;

   assign prod    = (2*RES_W)'(op_a) * (2*RES_W)'(op_b);
   assign prod_lo = prod[RES_W-1:0];
   assign hi_nz   = |prod[2*RES_W-1:RES_W];

endmodule

// File: rtl/pow_seq.sv
// LSB-first square-and-multiply sequencer computing base**exp mod 2**RES_W
// with a single multiplier shared between accumulate and square steps.
module pow_seq
   import pow_seq_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned EXP_W  = DEF_EXP_W,
   parameter int unsigned RES_W  = DEF_RES_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [EXP_W-1:0]  exp_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [RES_W-1:0]  data_out,
   output logic              out_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   state_t             state, state_nxt;
   logic [RES_W-1:0]   acc, acc_nxt;
   logic [RES_W-1:0]   b, b_nxt;
   logic [EXP_W-1:0]   e, e_nxt;
   logic               phase, phase_nxt;
   logic               ovf, ovf_nxt;
   logic               b_ovf, b_ovf_nxt;

   logic               sel_acc;
   logic [RES_W-1:0]   mul_a;
   logic [RES_W-1:0]   prod_lo;
   logic               hi_nz;

   // Accumulate step uses acc as left operand; every other RUN cycle squares b
   assign sel_acc = (state == ST_RUN) && !phase && e[0];
   assign mul_a   = sel_acc ? acc : b;

   pow_seq_mul_unit #(.RES_W(RES_W)) u_mul (
      .op_a    (mul_a),
      .op_b    (b),
      .prod_lo (prod_lo),
      .hi_nz   (hi_nz)
   );

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      b_nxt     = b;
      e_nxt     = e;
      phase_nxt = phase;
      ovf_nxt   = ovf;
      b_ovf_nxt = b_ovf;
      case (state)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               b_nxt     = RES_W'(data_in);
               e_nxt     = exp_in;
               acc_nxt   = RES_W'(1);
               ovf_nxt   = 1'b0;
               b_ovf_nxt = 1'b0;
               phase_nxt = 1'b0;
               state_nxt = (exp_in != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (sel_acc) begin
               acc_nxt   = prod_lo;
               ovf_nxt   = ovf | hi_nz | b_ovf;
               phase_nxt = 1'b1;
            end else begin
               // b overflow only matters once b is folded into acc, so the
               // trailing square never reaches ovf
               b_nxt     = prod_lo;
               b_ovf_nxt = b_ovf | hi_nz;
               e_nxt     = e >> 1;
               phase_nxt = 1'b0;
               if ((e >> 1) == '0) begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_valid && out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, datapath and registered handshake flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         acc       <= RES_W'(1);
         b         <= '0;
         e         <= '0;
         phase     <= 1'b0;
         ovf       <= 1'b0;
         b_ovf     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         b         <= b_nxt;
         e         <= e_nxt;
         phase     <= phase_nxt;
         ovf       <= ovf_nxt;
         b_ovf     <= b_ovf_nxt;
         in_ready  <= (state_nxt == ST_IDLE);
         out_valid <= (state == ST_DONE) && (state_nxt == ST_DONE);
         busy      <= (state_nxt != ST_IDLE);
      end
   end

   assign data_out = acc;
   assign out_ovf  = ovf;

endmodule

// File: tb/tb_pow_seq.sv
// Self-checking bench for pow_seq: directed table, random requests against an
// arithmetic power model, output stall, ignored requests and async reset.
module tb_pow_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  data_in = '0;
   logic [3:0]  exp_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] data_out;
   logic        out_ovf;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  base;
      logic [3:0]  ex;
      logic [31:0] res;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   pow_seq dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .exp_in    (exp_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, want);
      end
   endtask

   // Power by repeated multiplication; latency from exponent bit statistics
   function automatic void model(input logic [7:0] base, input logic [3:0] ex,
                                 output logic [31:0] res, output logic ovf, output int lat);
      longint unsigned a;
      longint unsigned p;
      int ones;
      int blen;
      a = 1;
      ovf = 1'b0;
      for (int i = 0; i < int'(ex); i++) begin
         p = a * longint'(base);
         if ((p >> 32) != 0) ovf = 1'b1;
         a = p & 64'hFFFF_FFFF;
      end
      res = 32'(a);
      ones = 0;
      blen = 0;
      for (int i = 0; i < 4; i++) begin
         if (ex[i]) begin
            ones++;
            blen = i + 1;
         end
      end
      lat = (ex == 4'd0) ? 1 : blen + ones + 1;
   endfunction

   task automatic txn(input logic [7:0] base, input logic [3:0] ex, input logic [31:0] res_x,
                      input logic ovf_x, input int lat_x, input int stall, input bit poke,
                      input string nm);
      bit got;
      int lat;
      @(negedge clk);
      data_in  = base;
      exp_in   = ex;
      in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({nm, " accept"}, 64'(got), 64'd1);
      if (!got) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (poke) begin
         data_in = ~base;
         exp_in  = ~ex;
      end else begin
         in_valid = 1'b0;
      end
      chk({nm, " in_ready low"}, 64'(in_ready), 64'd0);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      chk({nm, " latency"}, 64'(lat), 64'(lat_x));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk({nm, " hold valid"}, 64'(out_valid), 64'd1);
         chk({nm, " hold data"}, 64'(data_out), 64'(res_x));
      end
      in_valid = 1'b0;
      chk({nm, " data"}, 64'(data_out), 64'(res_x));
      chk({nm, " ovf"}, 64'(out_ovf), 64'(ovf_x));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, " valid drop"}, 64'(out_valid), 64'd0);
      chk({nm, " ready back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [7:0]  rb;
      logic [3:0]  re;
      logic [31:0] rr;
      logic        ro;
      int          rl;
      bit          seen;

      vecs[0] = '{base: 8'd3,   ex: 4'd4,  res: 32'd81,         ovf: 1'b0, lat: 5};
      vecs[1] = '{base: 8'd2,   ex: 4'd15, res: 32'd32768,      ovf: 1'b0, lat: 9};
      vecs[2] = '{base: 8'd16,  ex: 4'd8,  res: 32'd0,          ovf: 1'b1, lat: 6};
      vecs[3] = '{base: 8'd255, ex: 4'd4,  res: 32'd4228250625, ovf: 1'b0, lat: 5};
      vecs[4] = '{base: 8'd0,   ex: 4'd0,  res: 32'd1,          ovf: 1'b0, lat: 1};
      vecs[5] = '{base: 8'd7,   ex: 4'd0,  res: 32'd1,          ovf: 1'b0, lat: 1};
      vecs[6] = '{base: 8'd0,   ex: 4'd5,  res: 32'd0,          ovf: 1'b0, lat: 6};
      vecs[7] = '{base: 8'd5,   ex: 4'd3,  res: 32'd125,        ovf: 1'b0, lat: 5};

      #12;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset data_out", 64'(data_out), 64'd1);
      chk("reset out_ovf", 64'(out_ovf), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 8; i++) begin
         txn(vecs[i].base, vecs[i].ex, vecs[i].res, vecs[i].ovf, vecs[i].lat, 0, 1'b0,
             $sformatf("vec%0d", i));
      end

      // Stalled consumer plus requests poked while busy
      txn(8'd3, 4'd4, 32'd81, 1'b0, 5, 10, 1'b1, "stall");
      txn(8'd16, 4'd8, 32'd0, 1'b1, 6, 3, 1'b1, "stall_ovf");

      for (int i = 0; i < 30; i++) begin
         rb = 8'($urandom_range(0, 255));
         re = 4'($urandom_range(0, 15));
         model(rb, re, rr, ro, rl);
         txn(rb, re, rr, ro, rl, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d b=%0d e=%0d", i, rb, re));
      end

      // Async reset in the middle of a run
      @(negedge clk);
      data_in  = 8'd3;
      exp_in   = 4'd15;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("abort busy before reset", 64'(busy), 64'd1);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("abort out_valid", 64'(out_valid), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort data_out", 64'(data_out), 64'd1);
      chk("abort out_ovf", 64'(out_ovf), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort no valid pulse", 64'(seen), 64'd0);
      txn(8'd5, 4'd3, 32'd125, 1'b0, 5, 0, 1'b0, "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
